alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the execute stage. It performs the single-cycle integer ops (add, sub, logic, slt, shifts) with a registered result. It also runs iterative unsigned multiply and divide over WIDTH cycles. Operands enter and results leave through valid/ready handshakes, so the pipeline controller can stall on long ops instead of assuming fixed latency.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 100 ++++++++++
 rtl/alu_mc.sv | 181 ++++++++++++++++++
 tb/tb_alu_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - op code constants (4-bit)
//   - FSM state encoding (2-bit)
//   - is_iter_op(): true for ops that run through the iterative datapath
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply (shift-add) and restoring
// divide, one bit per cycle for WIDTH cycles.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load operands and begin (is_div selects divide)
//   a, b      : operands, sampled on start
//   done      : high during the last iteration cycle
//   lo, hi    : result of the current iteration step; valid when done
//               (product low/high, or quotient/remainder)
module alu_muldiv_iter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  // acc holds product-high / partial remainder; lo_reg holds the multiplier
  // (shifted out LSB first) or the dividend (becoming the quotient).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] lo_step;

  always_comb begin
    mul_sum = lo_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    div_rem = {acc_q, lo_q[WIDTH-1]};
    div_ge  = div_rem >= {1'b0, opnd_q};
    if (is_div_q) begin
      // Divide by zero falls out naturally: every step subtracts 0, so the
      // quotient fills with ones and the remainder collects the dividend.
      acc_step = div_ge ? WIDTH'(div_rem - {1'b0, opnd_q}) : div_rem[WIDTH-1:0];
      lo_step  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      lo_d     = is_div ? a : b;
      opnd_d   = is_div ? b : a;
      is_div_d = is_div;
      busy_d   = 1'b1;
      cnt_d    = SHW'(WIDTH - 1);
    end else if (busy_q) begin
      acc_d = acc_step;
      lo_d  = lo_step;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Expose the final step combinationally so the top can register the
  // result on the same edge that ends the last iteration.
  assign done = busy_q && (cnt_q == '0);
  assign lo   = lo_step;
  assign hi   = acc_step;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : request handshake; op, a, b captured on accept
//   out_valid/out_ready      : result handshake; outputs hold while stalled
//   result, result_hi        : primary / secondary result
//   zero, overflow,
//   div_by_zero, illegal     : status flags for the held result
//
// state   | meaning
// IDLE    | accepting; single-cycle ops complete here
// ITER    | MULU/DIVU iterating in alu_muldiv_iter
// DONE    | result just written, returns to IDLE
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             illegal_q, illegal_d;
  logic             is_div_q, is_div_d;
  logic             b_zero_q, b_zero_d;

  logic             accept;
  logic             start;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;
  logic [SHW-1:0]   shamt;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    shamt   = b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MULU, OP_DIVU: begin
      end
      default: alu_ill = 1'b1;
    endcase
  end

  assign in_ready = !rst && (state_q == ST_IDLE) && !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_iter_op(op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (op == OP_DIVU),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q && !out_ready;
    result_d      = result_q;
    result_hi_d   = result_hi_q;
    zero_d        = zero_q;
    overflow_d    = overflow_q;
    div_by_zero_d = div_by_zero_q;
    illegal_d     = illegal_q;
    is_div_d      = is_div_q;
    b_zero_d      = b_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter_op(op)) begin
            state_d  = ST_ITER;
            is_div_d = (op == OP_DIVU);
            b_zero_d = (b == '0);
          end else begin
            out_valid_d   = 1'b1;
            result_d      = alu_res;
            result_hi_d   = '0;
            zero_d        = (alu_res == '0);
            overflow_d    = alu_ovf;
            div_by_zero_d = 1'b0;
            illegal_d     = alu_ill;
          end
        end
      end
      ST_ITER: begin
        if (md_done) begin
          state_d       = ST_DONE;
          out_valid_d   = 1'b1;
          result_d      = md_lo;
          result_hi_d   = md_hi;
          zero_d        = (md_lo == '0);
          overflow_d    = 1'b0;
          div_by_zero_d = is_div_q && b_zero_q;
          illegal_d     = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      result_hi_q   <= '0;
      zero_q        <= 1'b0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      illegal_q     <= 1'b0;
      is_div_q      <= 1'b0;
      b_zero_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      result_hi_q   <= result_hi_d;
      zero_q        <= zero_d;
      overflow_q    <= overflow_d;
      div_by_zero_q <= div_by_zero_d;
      illegal_q     <= illegal_d;
      is_div_q      <= is_div_d;
      b_zero_q      <= b_zero_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, scoreboard-checked bench for alu_mc (WIDTH = 32).
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid, out_ready;
  logic [W-1:0] result, result_hi;
  logic         zero, overflow, div_by_zero, illegal;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .illegal     (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z, ov, dz, il;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] res, input logic [W-1:0] hi,
                      input logic z, input logic ov, input logic dz, input logic il);
    exp_t e;
    e.res = res; e.hi = hi; e.z = z; e.ov = ov; e.dz = dz; e.il = il;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, ".result"},    result,      e.res);
    chk({tag, ".result_hi"}, result_hi,   e.hi);
    chk({tag, ".zero"},      zero,        e.z);
    chk({tag, ".overflow"},  overflow,    e.ov);
    chk({tag, ".div0"},      div_by_zero, e.dz);
    chk({tag, ".illegal"},   illegal,     e.il);
  endtask

  // n = cycles after the accepting edge at which out_valid is first seen
  task automatic wait_out(input string tag, input int exp_lat);
    int n = 1;
    while (!out_valid && n < exp_lat + 10) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, exp_lat);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] res, input logic [W-1:0] hi,
                        input logic z, input logic ov, input logic dz, input logic il,
                        input int lat);
    out_ready = 1'b1;
    drive(o, x, y);
    chk({tag, ".in_ready"}, in_ready, 1);
    push(res, hi, z, ov, dz, il);
    tick();
    in_valid = 1'b0;
    wait_out(tag, lat);
    check_out(tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_ready",  in_ready,    0);
    chk("rst.out_valid", out_valid,   0);
    chk("rst.result",    result,      0);
    chk("rst.result_hi", result_hi,   0);
    chk("rst.flags",     {zero, overflow, div_by_zero, illegal}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", in_ready, 1);
    tick();

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 0, 0, 1);
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'h0, 0, 1, 0, 0, 0, 1);
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 0, 1, 0, 0, 1);
    run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 0, 0, 1);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 0, 0, 0, 1);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 0, 0, 1);
    run_op("srl", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 0, 0, 0, 0, 1);
    run_op("sll", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 0, 0, 0, 0, 0, 1);
    run_op("sra0", OP_SRA, 32'h8000_1234, 32'd0, 32'h8000_1234, 0, 0, 0, 0, 0, 1);
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0, 0, 1);
    run_op("or",  OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 0, 0, 1);
    run_op("ill", 4'd13, 32'h1234, 32'h5678, 32'h0, 0, 1, 0, 0, 1, 1);

    // back-to-back single-cycle ops, one per cycle
    out_ready = 1'b1;
    drive(OP_ADD, 32'd1, 32'd2);
    push(32'd3, 0, 0, 0, 0, 0);
    tick();
    drive(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    push(32'h5A5A_5A5A, 0, 0, 0, 0, 0);
    chk("b2b.in_ready", in_ready, 1);
    check_out("b2b.add");
    tick();
    drive(OP_SLL, 32'd3, 32'd4);
    push(32'h30, 0, 0, 0, 0, 0);
    check_out("b2b.xor");
    tick();
    in_valid = 1'b0;
    check_out("b2b.sll");
    tick();
    chk("b2b.drained", out_valid, 0);

    // MULU with a second request held on the input the whole time
    out_ready = 1'b0;
    drive(OP_MULU, 32'hFFFF, 32'hFFFF);
    chk("mul.in_ready", in_ready, 1);
    push(32'hFFFE_0001, 32'h0, 0, 0, 0, 0);
    tick();
    drive(OP_ADD, 32'd1, 32'd1);
    n = 1;
    while (!out_valid && n < W + 10) begin
      chk("mul.busy_in_ready", in_ready, 0);
      tick();
      n++;
    end
    chk("mul.latency", n, W + 1);
    check_out("mul");
    chk("mul.done_in_ready", in_ready, 0);
    tick();
    chk("mul.hold_valid", out_valid, 1);
    chk("mul.hold_in_ready", in_ready, 0);
    push(32'd2, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_out("held_add");
    tick();

    run_op("mul_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 0, 0, W + 1);
    run_op("div", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 0, W + 1);
    run_op("div0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 0, 1, 0, W + 1);

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    drive(OP_OR, 32'h1200_0000, 32'h0000_0034);
    push(32'h1200_0034, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid",    out_valid, 1);
      chk("bp.result",   result,    32'h1200_0034);
      chk("bp.in_ready", in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    check_out("bp");
    tick();
    chk("bp.released", out_valid, 0);

    // reset during ITER: no result may ever appear
    out_ready = 1'b1;
    drive(OP_MULU, 32'h1234, 32'h5678);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready",  in_ready,  0);
    chk("midrst.result",    result,    0);
    rst = 1'b0;
    #1;
    chk("midrst.in_ready_after", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("midrst.no_pulse", seen, 0);
    run_op("after_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 0, 1);

    chk("sb.empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
